// File: rtl/cortexm0_pmu_if.sv
// Cortex-M0 PMU signal bundle: core sleep status, WIC handshake and power controls.
// Modports: master = core/WIC side (drives requests), slave = PMU (drives controls).
interface cortexm0_pmu_if;

  logic PMUENABLE;
  logic SLEEPING;
  logic SLEEPDEEP;
  logic WICENACK;
  logic WAKEUP;
  logic WICENREQ;
  logic GATEHCLK;
  logic ISOLATEn;
  logic RETAINn;
  logic PWRDOWN;
`ifdef CORTEXM0_PMU_DBGPWR_EN
  logic CDBGPWRUPREQ;
  logic CDBGPWRUPACK;

  modport master (
    output PMUENABLE, SLEEPING, SLEEPDEEP,
    output WICENACK, WAKEUP, CDBGPWRUPREQ,
    input  WICENREQ, GATEHCLK, ISOLATEn,
    input  RETAINn, PWRDOWN, CDBGPWRUPACK
  );

  modport slave (
    input  PMUENABLE, SLEEPING, SLEEPDEEP,
    input  WICENACK, WAKEUP, CDBGPWRUPREQ,
    output WICENREQ, GATEHCLK, ISOLATEn,
    output RETAINn, PWRDOWN, CDBGPWRUPACK
  );
`else
  modport master (
    output PMUENABLE, SLEEPING, SLEEPDEEP,
    output WICENACK, WAKEUP,
    input  WICENREQ, GATEHCLK, ISOLATEn,
    input  RETAINn, PWRDOWN
  );

  modport slave (
    input  PMUENABLE, SLEEPING, SLEEPDEEP,
    input  WICENACK, WAKEUP,
    output WICENREQ, GATEHCLK, ISOLATEn,
    output RETAINn, PWRDOWN
  );
`endif

endinterface

// File: rtl/cortexm0_pmu.sv
// Cortex-M0 PMU: arms the WIC, sequences gate/isolate/retain/power-down and back.
// Ports: FCLK, RESET (sync, active-high), pmu (cortexm0_pmu_if.slave).
// Option CORTEXM0_PMU_DBGPWR_EN adds the CDBGPWRUPREQ/CDBGPWRUPACK debug power hold.
module cortexm0_pmu #(
  parameter int unsigned PWRUP_CYCLES = 4,
  parameter int unsigned CNTW         = 8
) (
  input  logic           FCLK,
  input  logic           RESET,
  cortexm0_pmu_if.slave  pmu
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ENREQ    = 4'd1,
    S_ARMED    = 4'd2,
    S_GATE     = 4'd3,
    S_ISOLATE  = 4'd4,
    S_RETAIN   = 4'd5,
    S_PWRDN    = 4'd6,
    S_PWRUP    = 4'd7,
    S_RESTORE  = 4'd8,
    S_UNISO    = 4'd9,
    S_UNGATE   = 4'd10,
    S_WAKEWAIT = 4'd11,
    S_DISREQ   = 4'd12
  } state_t;

  // A settle time of 0 behaves as 1 cycle.
  localparam int unsigned LOAD_V =
    (PWRUP_CYCLES == 0) ? 0 : PWRUP_CYCLES - 1;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(LOAD_V);

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic wicenreq_q, wicenreq_d;
  logic gatehclk_q, gatehclk_d;
  logic isolaten_q, isolaten_d;
  logic retainn_q, retainn_d;
  logic pwrdown_q, pwrdown_d;

  logic dbg_req;
  logic wake_dn;
  logic sleep_go;

`ifdef CORTEXM0_PMU_DBGPWR_EN
  logic dbgack_q, dbgack_d;
  assign dbg_req = pmu.CDBGPWRUPREQ;
`else
  assign dbg_req = 1'b0;
`endif

  // Debug power request aborts any descent just like WAKEUP.
  assign wake_dn  = pmu.WAKEUP | dbg_req;
  assign sleep_go = pmu.SLEEPING & pmu.SLEEPDEEP &
                    ~pmu.WAKEUP & ~dbg_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE:
        if (pmu.PMUENABLE) state_d = S_ENREQ;
      S_ENREQ:
        if (!pmu.PMUENABLE)    state_d = S_DISREQ;
        else if (pmu.WICENACK) state_d = S_ARMED;
      S_ARMED:
        if (!pmu.PMUENABLE) state_d = S_DISREQ;
        else if (sleep_go)  state_d = S_GATE;
      S_GATE:
        state_d = wake_dn ? S_UNGATE : S_ISOLATE;
      S_ISOLATE:
        state_d = wake_dn ? S_UNISO : S_RETAIN;
      S_RETAIN:
        state_d = wake_dn ? S_RESTORE : S_PWRDN;
      S_PWRDN:
        if (wake_dn) begin
          state_d = S_PWRUP;
          cnt_d   = CNT_LOAD;
        end
      S_PWRUP:
        if (cnt_q == '0) state_d = S_RESTORE;
        else             cnt_d   = cnt_q - 1'b1;
      S_RESTORE:  state_d = S_UNISO;
      S_UNISO:    state_d = S_UNGATE;
      S_UNGATE:   state_d = S_WAKEWAIT;
      S_WAKEWAIT:
        if (!pmu.SLEEPING) state_d = S_ARMED;
      S_DISREQ:
        if (!pmu.WICENACK) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are the decode of the next state, registered so they
  // always equal the decode of the current state.
  always_comb begin
    wicenreq_d = 1'b1;
    gatehclk_d = 1'b0;
    isolaten_d = 1'b1;
    retainn_d  = 1'b1;
    pwrdown_d  = 1'b0;
    unique case (state_d)
      S_IDLE, S_DISREQ:
        wicenreq_d = 1'b0;
      S_GATE, S_UNISO:
        gatehclk_d = 1'b1;
      S_ISOLATE, S_RESTORE: begin
        gatehclk_d = 1'b1;
        isolaten_d = 1'b0;
      end
      S_RETAIN, S_PWRUP: begin
        gatehclk_d = 1'b1;
        isolaten_d = 1'b0;
        retainn_d  = 1'b0;
      end
      S_PWRDN: begin
        gatehclk_d = 1'b1;
        isolaten_d = 1'b0;
        retainn_d  = 1'b0;
        pwrdown_d  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CORTEXM0_PMU_DBGPWR_EN
  always_comb begin
    dbgack_d = 1'b0;
    unique case (state_q)
      S_IDLE, S_ENREQ, S_ARMED,
      S_WAKEWAIT, S_DISREQ:
        dbgack_d = dbg_req;
      default: dbgack_d = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge FCLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wicenreq_q <= 1'b0;
      gatehclk_q <= 1'b0;
      isolaten_q <= 1'b1;
      retainn_q  <= 1'b1;
      pwrdown_q  <= 1'b0;
`ifdef CORTEXM0_PMU_DBGPWR_EN
      dbgack_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wicenreq_q <= wicenreq_d;
      gatehclk_q <= gatehclk_d;
      isolaten_q <= isolaten_d;
      retainn_q  <= retainn_d;
      pwrdown_q  <= pwrdown_d;
`ifdef CORTEXM0_PMU_DBGPWR_EN
      dbgack_q   <= dbgack_d;
`endif
    end
  end

  assign pmu.WICENREQ = wicenreq_q;
  assign pmu.GATEHCLK = gatehclk_q;
  assign pmu.ISOLATEn = isolaten_q;
  assign pmu.RETAINn  = retainn_q;
  assign pmu.PWRDOWN  = pwrdown_q;
`ifdef CORTEXM0_PMU_DBGPWR_EN
  assign pmu.CDBGPWRUPACK = dbgack_q;
`endif

  // Isolation must cover retention/power-off; gating must cover isolation.
  a_pwr_order: assert property (
    @(posedge FCLK) disable iff (RESET)
      ((!retainn_q || pwrdown_q) -> !isolaten_q) &&
      (!isolaten_q -> gatehclk_q)
  );

endmodule

// File: tb/tb_cortexm0_pmu.sv
// Self-checking bench for cortexm0_pmu: directed scenarios plus random traffic
// compared cycle by cycle against a depth-based behavioural model.
module tb_cortexm0_pmu;

  localparam int unsigned PWRUP = 4;
  localparam int NSET = (PWRUP == 0) ? 1 : PWRUP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cortexm0_pmu_if intf ();

  cortexm0_pmu #(.PWRUP_CYCLES(PWRUP), .CNTW(8)) dut (
    .FCLK  (clk),
    .RESET (rst),
    .pmu   (intf.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: WIC phase (0 idle,1 req,2 on,3 disable) and power depth
  // 0 awake,1 gated,2 isolated,3 retained,4 off.
  int m_phase, m_depth, m_settle;
  bit m_rise, m_fall, m_ww, m_ack;
  bit dbg;

  function automatic logic [4:0] obs();
    return {intf.WICENREQ, intf.GATEHCLK, intf.ISOLATEn,
            intf.RETAINn, intf.PWRDOWN};
  endfunction

  function automatic logic [4:0] expv();
    logic [4:0] v;
    v[4] = (m_phase == 1) || (m_phase == 2);
    v[3] = m_depth >= 1;
    v[2] = !(m_depth >= 2);
    v[1] = !(m_depth >= 3);
    v[0] = m_depth == 4;
    return v;
  endfunction

  task automatic model_step();
    bit wk;
    if (rst) begin
      m_phase = 0; m_depth = 0; m_settle = 0;
      m_rise = 0; m_fall = 0; m_ww = 0; m_ack = 0;
      return;
    end
    m_ack = dbg && (m_phase != 2 ||
            (m_depth == 0 && !m_rise && !m_fall));
    wk = intf.WAKEUP || dbg;
    case (m_phase)
      0: if (intf.PMUENABLE) m_phase = 1;
      1: if (!intf.PMUENABLE) m_phase = 3;
         else if (intf.WICENACK) m_phase = 2;
      3: if (!intf.WICENACK) m_phase = 0;
      default: begin
        if (m_ww) begin
          if (!intf.SLEEPING) m_ww = 0;
        end else if (m_rise) begin
          if (m_settle > 0) m_settle--;
          else if (m_depth > 0) m_depth--;
          else begin m_rise = 0; m_ww = 1; end
        end else if (m_fall) begin
          if (m_depth == 4) begin
            if (wk) begin
              m_depth = 3; m_settle = NSET - 1;
              m_fall = 0; m_rise = 1;
            end
          end else if (wk) begin
            m_depth--; m_fall = 0; m_rise = 1;
          end else m_depth++;
        end else begin
          if (!intf.PMUENABLE) m_phase = 3;
          else if (intf.SLEEPING && intf.SLEEPDEEP &&
                   !intf.WAKEUP && !dbg) begin
            m_depth = 1; m_fall = 1;
          end
        end
      end
    endcase
  endtask

  task automatic step();
`ifdef CORTEXM0_PMU_DBGPWR_EN
    dbg = intf.CDBGPWRUPREQ;
`else
    dbg = 1'b0;
`endif
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    intf.PMUENABLE = 0; intf.SLEEPING = 0;
    intf.SLEEPDEEP = 0; intf.WICENACK = 0;
    intf.WAKEUP = 0;
`ifdef CORTEXM0_PMU_DBGPWR_EN
    intf.CDBGPWRUPREQ = 0;
`endif
    step(); step();
    n_chk++;
    if (obs() !== 5'b00110) begin
      n_fail++;
      $display("FAIL reset got %b want 00110", obs());
    end
    rst = 1'b0;
  endtask

  task automatic test_enable();
    intf.PMUENABLE = 1;
    step();
    n_chk++;
    if (obs() !== 5'b10110) begin
      n_fail++;
      $display("FAIL en_req got %b want 10110", obs());
    end
    step(); step();
    intf.WICENACK = 1;
    step();
    n_chk++;
    if (obs() !== 5'b10110 || m_phase != 2) begin
      n_fail++;
      $display("FAIL armed got %b want 10110 ph %0d",
               obs(), m_phase);
    end
  endtask

  task automatic test_deep_sleep();
    logic [4:0] seq [$];
    seq = '{5'b11110, 5'b11010, 5'b11000, 5'b11001};
    intf.SLEEPING = 1; intf.SLEEPDEEP = 1;
    foreach (seq[i]) begin
      step();
      n_chk++;
      if (obs() !== seq[i] || obs() !== expv()) begin
        n_fail++;
        $display("FAIL entry%0d got %b want %b", i, obs(), seq[i]);
      end
    end
    for (int i = 0; i < 9; i++) step();
    intf.WAKEUP = 1;
    step();
    intf.WAKEUP = 0;
    seq = '{5'b11000, 5'b11000, 5'b11000, 5'b11000,
            5'b11010, 5'b11110, 5'b10110, 5'b10110, 5'b10110};
    foreach (seq[i]) begin
      n_chk++;
      if (obs() !== seq[i] || obs() !== expv()) begin
        n_fail++;
        $display("FAIL exit%0d got %b want %b", i, obs(), seq[i]);
      end
      step();
    end
    intf.SLEEPING = 0;
    step();
    n_chk++;
    if (obs() !== 5'b10110 || m_ww || m_depth != 0) begin
      n_fail++;
      $display("FAIL rearm got %b want 10110", obs());
    end
  endtask

  task automatic test_abort();
    bit bad = 0;
    int gate_lo = -1;
    intf.SLEEPING = 1; intf.SLEEPDEEP = 1;
    step();
    n_chk++;
    if (obs() !== 5'b11110) begin
      n_fail++;
      $display("FAIL abort_gate got %b want 11110", obs());
    end
    intf.WAKEUP = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (!intf.ISOLATEn || !intf.RETAINn || intf.PWRDOWN)
        bad = 1;
      if (!intf.GATEHCLK && gate_lo < 0) gate_lo = i + 1;
      if (obs() !== expv()) bad = 1;
    end
    n_chk++;
    if (bad || gate_lo < 1 || gate_lo > 3) begin
      n_fail++;
      $display("FAIL abort got bad=%0d gate_lo=%0d want 0,1..3",
               bad, gate_lo);
    end
    intf.WAKEUP = 0; intf.SLEEPING = 0;
    step();
  endtask

  task automatic test_disable();
    bit bad = 0;
    intf.PMUENABLE = 0;
    step();
    n_chk++;
    if (obs() !== 5'b00110) begin
      n_fail++;
      $display("FAIL dis_req got %b want 00110", obs());
    end
    step();
    intf.WICENACK = 0;
    step();
    n_chk++;
    if (obs() !== expv() || m_phase != 0) begin
      n_fail++;
      $display("FAIL dis_idle got %b want %b", obs(), expv());
    end
    intf.PMUENABLE = 1;
    step();
    intf.WICENACK = 1;
    step();
    intf.SLEEPING = 1; intf.SLEEPDEEP = 1;
    for (int i = 0; i < 4; i++) step();
    intf.PMUENABLE = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (!intf.PWRDOWN || !intf.WICENREQ) bad = 1;
    end
    intf.WAKEUP = 1;
    step();
    intf.WAKEUP = 0;
    for (int i = 0; i < 10; i++) begin
      if (!intf.WICENREQ || obs() !== expv()) bad = 1;
      step();
    end
    n_chk++;
    if (bad) begin
      n_fail++;
      $display("FAIL defer got req lost want req held");
    end
    intf.SLEEPING = 0;
    step();
    n_chk++;
    if (obs() !== 5'b10110) begin
      n_fail++;
      $display("FAIL defer_arm got %b want 10110", obs());
    end
    step();
    n_chk++;
    if (obs() !== 5'b00110) begin
      n_fail++;
      $display("FAIL defer_dis got %b want 00110", obs());
    end
    intf.WICENACK = 0;
    step();
  endtask

  task automatic test_reset_pwrdn();
    intf.PMUENABLE = 1;
    step();
    intf.WICENACK = 1;
    step();
    intf.SLEEPING = 1; intf.SLEEPDEEP = 1;
    for (int i = 0; i < 6; i++) step();
    n_chk++;
    if (obs() !== 5'b11001) begin
      n_fail++;
      $display("FAIL rst_pre got %b want 11001", obs());
    end
    rst = 1'b1;
    step();
    n_chk++;
    if (obs() !== 5'b00110) begin
      n_fail++;
      $display("FAIL rst_pwrdn got %b want 00110", obs());
    end
    rst = 1'b0;
    intf.WICENACK = 0; intf.SLEEPING = 0;
    intf.PMUENABLE = 0;
    step();
  endtask

`ifdef CORTEXM0_PMU_DBGPWR_EN
  task automatic test_dbgpwr();
    bit bad = 0;
    intf.PMUENABLE = 1;
    step();
    intf.WICENACK = 1;
    step();
    intf.SLEEPING = 1; intf.SLEEPDEEP = 1;
    for (int i = 0; i < 6; i++) step();
    intf.CDBGPWRUPREQ = 1;
    step();
    n_chk++;
    if (obs() !== 5'b11000) begin
      n_fail++;
      $display("FAIL dbg_up got %b want 11000", obs());
    end
    for (int i = 0; i < 7; i++) begin
      step();
      if (obs() !== expv() ||
          intf.CDBGPWRUPACK !== m_ack) bad = 1;
    end
    step();
    n_chk++;
    if (intf.CDBGPWRUPACK !== 1'b1 || bad) begin
      n_fail++;
      $display("FAIL dbg_ack got %b bad=%0d want 1",
               intf.CDBGPWRUPACK, bad);
    end
    intf.SLEEPING = 0;
    step();
    intf.SLEEPING = 1;
    for (int i = 0; i < 3; i++) step();
    n_chk++;
    if (intf.GATEHCLK !== 1'b0) begin
      n_fail++;
      $display("FAIL dbg_block got %b want 0", intf.GATEHCLK);
    end
    intf.CDBGPWRUPREQ = 0;
    intf.SLEEPING = 0;
    intf.PMUENABLE = 0;
    step();
    intf.WICENACK = 0;
    step(); step();
  endtask
`endif

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 39) == 0)
        intf.PMUENABLE = ~intf.PMUENABLE;
      if (!intf.PMUENABLE && $urandom_range(0, 3) == 0)
        intf.PMUENABLE = 1;
      if (intf.WICENACK != intf.WICENREQ &&
          $urandom_range(0, 2) == 0)
        intf.WICENACK = intf.WICENREQ;
      if ($urandom_range(0, 5) == 0)
        intf.SLEEPING = ~intf.SLEEPING;
      intf.SLEEPDEEP = ($urandom_range(0, 3) != 0);
      intf.WAKEUP = ($urandom_range(0, 9) == 0);
`ifdef CORTEXM0_PMU_DBGPWR_EN
      intf.CDBGPWRUPREQ = ($urandom_range(0, 29) == 0);
`endif
      step();
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++;
        errs++;
        if (errs < 10)
          $display("FAIL rand%0d got %b want %b", i, obs(), expv());
      end
`ifdef CORTEXM0_PMU_DBGPWR_EN
      n_chk++;
      if (intf.CDBGPWRUPACK !== m_ack) begin
        n_fail++;
        $display("FAIL rand_ack%0d got %b want %b",
                 i, intf.CDBGPWRUPACK, m_ack);
      end
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_enable();
    test_deep_sleep();
    test_abort();
    test_disable();
    test_reset_pwrdn();
`ifdef CORTEXM0_PMU_DBGPWR_EN
    test_dbgpwr();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
